// File: rtl/narnet_pkg.sv
// -----------------------------------------------------------------------------
// narnet_pkg
// Shared definitions for the NARNET stream controller slice.
//   N_DEF / Q_DEF     default sample width and fractional bits (signed fixed point)
//   TIMEOUT_DEF       default number of WAIT cycles before a core result is
//                     declared lost
//   state_t / ST_*    controller state encoding
//   cnt_width()       bit width needed to hold a counter value 0..max_val
// -----------------------------------------------------------------------------
package narnet_pkg;

    localparam int N_DEF       = 10;
    localparam int Q_DEF       = 9;
    localparam int TIMEOUT_DEF = 1023;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_EMIT  = 3'd3;
    localparam state_t ST_ERR   = 3'd4;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/narnet_watchdog.sv
// -----------------------------------------------------------------------------
// narnet_watchdog
// Result timeout counter. A clear reloads it with TIMEOUT-1; every enabled
// cycle counts it down. expired is high in the enabled cycle that is the
// TIMEOUT-th one since the clear, so the waiting state lasts at most TIMEOUT
// cycles.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      reload the counter (controller is issuing to the core)
//   enable     count this cycle (controller is waiting for the core)
//   expired    terminal count reached while enabled
// -----------------------------------------------------------------------------
module narnet_watchdog
    import narnet_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = cnt_width(TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= W'(TIMEOUT - 1);
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = enable && (count == '0);

endmodule

// File: rtl/narnet_stream_ctrl.sv
// -----------------------------------------------------------------------------
// narnet_stream_ctrl
// Sequences one sample at a time through an external predictor core:
// accepts an upstream sample, strobes it into the core, waits (bounded) for
// the core result and presents it downstream as a prediction. A lost result
// puts the core through a two-cycle reset and raises a sticky err flag.
//
// Optional feature (macro NARNET_CLOSED_LOOP_EN): the horizon input is
// latched with each accepted sample and every emitted prediction is fed back
// as the next core input until horizon extra predictions have been produced.
// Without the macro the horizon port does not exist.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready/s_data   upstream sample handshake (signed, N bits)
//   m_valid/m_ready/m_data   downstream prediction handshake (signed, N bits)
//   core_x, core_x_ready     sample and one-cycle start strobe to the core
//   core_enable, core_rst    core enable (low only in ERR), core reset
//   core_y, core_out_ready   core result and its one-cycle strobe
//   horizon                  closed-loop extra step count (macro only)
//   err                      sticky timeout flag, cleared only by rst
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for an upstream sample
// ISSUE | core_x_ready pulse, watchdog reload
// WAIT  | waiting for core_out_ready, watchdog counting
// EMIT  | prediction held on m_data until m_ready
// ERR   | core held in reset for two cycles after a timeout
// -----------------------------------------------------------------------------
module narnet_stream_ctrl
    import narnet_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int Q       = Q_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_data,
    output logic [N-1:0] core_x,
    output logic         core_x_ready,
    output logic         core_enable,
    output logic         core_rst,
    input  logic [N-1:0] core_y,
    input  logic         core_out_ready,
`ifdef NARNET_CLOSED_LOOP_EN
    input  logic [7:0]   horizon,
`endif
    output logic         err
);

    // Q only tags the fixed-point format; reject a format that cannot exist.
    if ((Q < 0) || (Q >= N)) begin : g_bad_q_format
        $error("narnet_stream_ctrl: Q must lie in 0..N-1");
    end

    state_t state;
    logic   rst_d;
    logic   err_hold;
    logic   wd_expired;

`ifdef NARNET_CLOSED_LOOP_EN
    logic [7:0] steps_left;
`endif

    narnet_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_ISSUE),
        .enable  (state == ST_WAIT),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            core_x   <= '0;
            m_data   <= '0;
            err      <= 1'b0;
            err_hold <= 1'b0;
            rst_d    <= 1'b1;
`ifdef NARNET_CLOSED_LOOP_EN
            steps_left <= '0;
`endif
        end else begin
            rst_d <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        core_x <= s_data;
`ifdef NARNET_CLOSED_LOOP_EN
                        steps_left <= horizon;
`endif
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    // A result arriving on the last allowed cycle still wins.
                    if (core_out_ready) begin
                        m_data <= core_y;
                        state  <= ST_EMIT;
                    end else if (wd_expired) begin
                        err      <= 1'b1;
                        err_hold <= 1'b1;
                        state    <= ST_ERR;
                    end
                end
                ST_EMIT: begin
                    if (m_ready) begin
`ifdef NARNET_CLOSED_LOOP_EN
                        if (steps_left != '0) begin
                            steps_left <= steps_left - 8'd1;
                            core_x     <= m_data;
                            state      <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
`else
                        state <= ST_IDLE;
`endif
                    end
                end
                ST_ERR: begin
                    if (err_hold) begin
                        err_hold <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready      = (state == ST_IDLE);
    assign core_x_ready = (state == ST_ISSUE);
    assign m_valid      = (state == ST_EMIT);
    assign core_enable  = (state != ST_ERR);
    // rst_d stretches the core reset one cycle past the controller reset.
    assign core_rst     = rst | rst_d | (state == ST_ERR);

endmodule

// File: tb/tb_narnet_stream_ctrl.sv
module tb_narnet_stream_ctrl;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic [N-1:0] s_data = '0;
    logic         m_ready = 1'b0;
    logic [N-1:0] core_y = '0;
    logic         core_out_ready = 1'b0;
    logic         s_ready, m_valid, core_x_ready, core_enable, core_rst, err;
    logic [N-1:0] m_data, core_x;
`ifdef NARNET_CLOSED_LOOP_EN
    logic [7:0]   horizon = 8'd0;
    logic [7:0]   t_horizon = 8'd0;
`endif

    // second instance with a short timeout for the lost-result scenario
    logic         t_s_valid = 1'b0;
    logic [N-1:0] t_s_data = '0;
    logic         t_m_ready = 1'b0;
    logic [N-1:0] t_core_y = '0;
    logic         t_core_out_ready = 1'b0;
    logic         t_s_ready, t_m_valid, t_core_x_ready, t_core_enable, t_core_rst, t_err;
    logic [N-1:0] t_m_data, t_core_x;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] last_out = '0;

    always #5 clk = ~clk;

    narnet_stream_ctrl dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .core_x(core_x), .core_x_ready(core_x_ready),
        .core_enable(core_enable), .core_rst(core_rst),
        .core_y(core_y), .core_out_ready(core_out_ready),
`ifdef NARNET_CLOSED_LOOP_EN
        .horizon(horizon),
`endif
        .err(err)
    );

    narnet_stream_ctrl #(.TIMEOUT(100)) dut_to (
        .clk(clk), .rst(rst),
        .s_valid(t_s_valid), .s_ready(t_s_ready), .s_data(t_s_data),
        .m_valid(t_m_valid), .m_ready(t_m_ready), .m_data(t_m_data),
        .core_x(t_core_x), .core_x_ready(t_core_x_ready),
        .core_enable(t_core_enable), .core_rst(t_core_rst),
        .core_y(t_core_y), .core_out_ready(t_core_out_ready),
`ifdef NARNET_CLOSED_LOOP_EN
        .horizon(t_horizon),
`endif
        .err(t_err)
    );

    // behavioural predictor used for randomized traffic
    function automatic logic [N-1:0] core_fn(input logic [N-1:0] x);
        return N'(32'(x) * 5 + 3);
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        n_checks++; if (core_x_ready !== 1'b0) begin n_fail++; $display("FAIL reset_core_x_ready got=%b exp=0", core_x_ready); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
        n_checks++; if (core_x !== '0) begin n_fail++; $display("FAIL reset_core_x got=%h exp=0", core_x); end
        n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
        n_checks++; if (t_s_ready !== 1'b1 || t_err !== 1'b0) begin n_fail++; $display("FAIL reset_to_inst got s_ready=%b err=%b exp 1/0", t_s_ready, t_err); end
        rst = 1'b0;
        #1;
        n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst_stretch got=%b exp=1", core_rst); end
        @(negedge clk);
        n_checks++; if (core_rst !== 1'b0 || core_enable !== 1'b1) begin n_fail++; $display("FAIL reset_core_release got rst=%b en=%b exp 0/1", core_rst, core_enable); end
    endtask

    task automatic test_open_loop;
        logic [N-1:0] x = 10'h0C0;
        logic [N-1:0] y = 10'h155;
        int extra = 0;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL open_s_ready got=%b exp=1", s_ready); end
        s_valid = 1'b1; s_data = x;
        @(negedge clk);
        s_valid = 1'b0;
        n_checks++; if (core_x_ready !== 1'b1) begin n_fail++; $display("FAIL open_core_x_ready got=%b exp=1", core_x_ready); end
        n_checks++; if (core_x !== x) begin n_fail++; $display("FAIL open_core_x got=%h exp=%h", core_x, x); end
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (core_x_ready !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0) extra++;
            if (k == 300) begin core_out_ready = 1'b1; core_y = y; end
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL open_wait_quiet got=%0d bad cycles exp=0", extra); end
        @(negedge clk);
        core_out_ready = 1'b0;
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL open_m_valid got=%b exp=1", m_valid); end
        n_checks++; if (m_data !== y) begin n_fail++; $display("FAIL open_m_data got=%h exp=%h", m_data, y); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        n_checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL open_done got m_valid=%b s_ready=%b exp 0/1", m_valid, s_ready); end
        last_out = y;
    endtask

    task automatic test_backpressure;
        logic [N-1:0] x = 10'h1A3;
        logic [N-1:0] y = 10'h2F0;
        int bad = 0;
        s_valid = 1'b1; s_data = x;
        @(negedge clk);
        s_valid = 1'b0;
        n_checks++; if (core_x_ready !== 1'b1 || core_x !== x) begin n_fail++; $display("FAIL bp_issue got strobe=%b x=%h exp 1/%h", core_x_ready, core_x, x); end
        repeat (5) @(negedge clk);
        core_out_ready = 1'b1; core_y = y;
        @(negedge clk);
        core_out_ready = 1'b0; core_y = 10'h000;
        n_checks++; if (m_valid !== 1'b1 || m_data !== y) begin n_fail++; $display("FAIL bp_emit got v=%b d=%h exp 1/%h", m_valid, m_data, y); end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_data !== y || s_ready !== 1'b0 || core_x_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        n_checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_done got m_valid=%b s_ready=%b exp 0/1", m_valid, s_ready); end
        last_out = y;
    endtask

    task automatic test_stray_strobe;
        int bad = 0;
        core_out_ready = 1'b1; core_y = 10'h3FF;
        @(negedge clk);
        core_out_ready = 1'b0;
        repeat (3) begin
            if (m_valid !== 1'b0 || s_ready !== 1'b1 || core_x_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stray_state got=%0d bad cycles exp=0", bad); end
        n_checks++; if (m_data !== last_out) begin n_fail++; $display("FAIL stray_m_data got=%h exp=%h", m_data, last_out); end
    endtask

    task automatic test_timeout;
        int bad = 0;
        n_checks++; if (t_s_ready !== 1'b1) begin n_fail++; $display("FAIL to_s_ready got=%b exp=1", t_s_ready); end
        t_s_valid = 1'b1; t_s_data = 10'h055;
        @(negedge clk);
        t_s_valid = 1'b0;
        n_checks++; if (t_core_x_ready !== 1'b1) begin n_fail++; $display("FAIL to_issue got=%b exp=1", t_core_x_ready); end
        // WAIT cycles 1..100: nothing yet; the edge closing cycle 100 sets err
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (t_err !== 1'b0 || t_m_valid !== 1'b0 || t_core_rst !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL to_wait got=%0d bad cycles exp=0", bad); end
        @(negedge clk);
        n_checks++; if (t_err !== 1'b1) begin n_fail++; $display("FAIL to_err got=%b exp=1", t_err); end
        n_checks++; if (t_core_rst !== 1'b1 || t_core_enable !== 1'b0 || t_s_ready !== 1'b0) begin n_fail++; $display("FAIL to_err_c1 got rst=%b en=%b rdy=%b exp 1/0/0", t_core_rst, t_core_enable, t_s_ready); end
        @(negedge clk);
        n_checks++; if (t_core_rst !== 1'b1 || t_core_enable !== 1'b0) begin n_fail++; $display("FAIL to_err_c2 got rst=%b en=%b exp 1/0", t_core_rst, t_core_enable); end
        @(negedge clk);
        n_checks++; if (t_core_rst !== 1'b0 || t_core_enable !== 1'b1 || t_s_ready !== 1'b1 || t_m_valid !== 1'b0) begin n_fail++; $display("FAIL to_recover got rst=%b en=%b rdy=%b mv=%b exp 0/1/1/0", t_core_rst, t_core_enable, t_s_ready, t_m_valid); end
        repeat (5) @(negedge clk);
        n_checks++; if (t_err !== 1'b1 || t_m_valid !== 1'b0) begin n_fail++; $display("FAIL to_sticky got err=%b mv=%b exp 1/0", t_err, t_m_valid); end
    endtask

    task automatic test_reset_mid_wait;
        logic [N-1:0] x2 = 10'h0BB;
        logic [N-1:0] y2;
        int bad = 0;
        s_valid = 1'b1; s_data = 10'h0AA;
        @(negedge clk);
        s_valid = 1'b0;
        n_checks++; if (core_x_ready !== 1'b1) begin n_fail++; $display("FAIL rmw_issue got=%b exp=1", core_x_ready); end
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_after_rst got rdy=%b mv=%b exp 1/0", s_ready, m_valid); end
        n_checks++; if (m_data !== '0 || core_x !== '0) begin n_fail++; $display("FAIL rmw_cleared got m_data=%h core_x=%h exp 0/0", m_data, core_x); end
        n_checks++; if (t_err !== 1'b0) begin n_fail++; $display("FAIL rmw_err_cleared got=%b exp=0", t_err); end
        last_out = '0;
        repeat (3) @(negedge clk);
        core_out_ready = 1'b1; core_y = 10'h111;
        @(negedge clk);
        core_out_ready = 1'b0;
        repeat (5) begin
            if (m_valid !== 1'b0 || s_ready !== 1'b1) bad++;
            @(negedge clk);
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rmw_stale got=%0d bad cycles exp=0", bad); end
        y2 = core_fn(x2);
        s_valid = 1'b1; s_data = x2;
        @(negedge clk);
        s_valid = 1'b0;
        n_checks++; if (core_x_ready !== 1'b1 || core_x !== x2) begin n_fail++; $display("FAIL rmw_next_issue got strobe=%b x=%h exp 1/%h", core_x_ready, core_x, x2); end
        repeat (10) @(negedge clk);
        core_out_ready = 1'b1; core_y = y2;
        @(negedge clk);
        core_out_ready = 1'b0;
        n_checks++; if (m_valid !== 1'b1 || m_data !== y2) begin n_fail++; $display("FAIL rmw_next_emit got v=%b d=%h exp 1/%h", m_valid, m_data, y2); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        last_out = y2;
    endtask

    task automatic test_random;
        logic [N-1:0] x, exp_y;
        int d, bp, bad;
        for (int it = 0; it < 12; it++) begin
            x = N'($urandom);
            d = $urandom_range(1, 40);
            bp = $urandom_range(0, 4);
            exp_y = core_fn(x);
            bad = 0;
            n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_s_ready got=%b exp=1", it, s_ready); end
            s_valid = 1'b1; s_data = x;
            @(negedge clk);
            s_valid = 1'b0;
            n_checks++; if (core_x_ready !== 1'b1 || core_x !== x) begin n_fail++; $display("FAIL rnd%0d_issue got strobe=%b x=%h exp 1/%h", it, core_x_ready, core_x, x); end
            for (int k = 1; k <= d; k++) begin
                @(negedge clk);
                if (m_valid !== 1'b0 || core_x_ready !== 1'b0) bad++;
                if (k == d) begin core_out_ready = 1'b1; core_y = exp_y; end
            end
            @(negedge clk);
            core_out_ready = 1'b0; core_y = ~exp_y;
            n_checks++; if (m_valid !== 1'b1 || m_data !== exp_y) begin n_fail++; $display("FAIL rnd%0d_emit got v=%b d=%h exp 1/%h", it, m_valid, m_data, exp_y); end
            for (int b = 0; b < bp; b++) begin
                @(negedge clk);
                if (m_valid !== 1'b1 || m_data !== exp_y) bad++;
            end
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
            n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rnd%0d_timing got=%0d bad cycles exp=0", it, bad); end
            n_checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_done got mv=%b rdy=%b exp 0/1", it, m_valid, s_ready); end
            last_out = exp_y;
        end
    endtask

`ifdef NARNET_CLOSED_LOOP_EN
    task automatic test_closed_loop;
        logic [N-1:0] exp_q[$];
        logic [N-1:0] v, in_v;
        int d;
        v = 10'h010;
        for (int i = 0; i <= 3; i++) begin v = v + 10'd1; exp_q.push_back(v); end
        in_v = 10'h010;
        horizon = 8'd3;
        s_valid = 1'b1; s_data = in_v;
        @(negedge clk);
        s_valid = 1'b0;
        horizon = 8'd0;
        for (int j = 0; j <= 3; j++) begin
            n_checks++; if (core_x_ready !== 1'b1 || core_x !== in_v) begin n_fail++; $display("FAIL cl%0d_issue got strobe=%b x=%h exp 1/%h", j, core_x_ready, core_x, in_v); end
            d = $urandom_range(1, 10);
            repeat (d) @(negedge clk);
            core_out_ready = 1'b1; core_y = in_v + 10'd1;
            @(negedge clk);
            core_out_ready = 1'b0;
            n_checks++; if (m_valid !== 1'b1 || m_data !== exp_q[j]) begin n_fail++; $display("FAIL cl%0d_emit got v=%b d=%h exp 1/%h", j, m_valid, m_data, exp_q[j]); end
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
            in_v = exp_q[j];
        end
        n_checks++; if (s_ready !== 1'b1 || core_x_ready !== 1'b0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL cl_end got rdy=%b strobe=%b mv=%b exp 1/0/0", s_ready, core_x_ready, m_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_open_loop();
        test_backpressure();
        test_stray_strobe();
        test_timeout();
        test_reset_mid_wait();
        test_random();
`ifdef NARNET_CLOSED_LOOP_EN
        test_closed_loop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
